// File: rtl/tlb_op_seq_pkg.sv
// Shared definitions for the TLB maintenance sequencer: op codes and FSM states.
package tlb_op_seq_pkg;

  localparam logic [1:0] TLBOP_P  = 2'd0;
  localparam logic [1:0] TLBOP_R  = 2'd1;
  localparam logic [1:0] TLBOP_WI = 2'd2;
  localparam logic [1:0] TLBOP_WR = 2'd3;

  localparam int STARVE_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SRCH    = 3'd1,
    PCOMMIT = 3'd2,
    RD      = 3'd3,
    RCOMMIT = 3'd4,
    WR      = 3'd5,
    RFQ     = 3'd6
  } tlb_state_t;

endpackage

// File: rtl/tlb_search_arb.sv
// Search-port arbiter: MEM normally owns the port; TLBP takes it when MEM is idle
// or after being denied STARVE_MAX-1 consecutive cycles.
module tlb_search_arb
  import tlb_op_seq_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic mem_s_req,
  output logic grant,
  output logic s_own,
  output logic mem_s_stall
);

  localparam logic [STARVE_W-1:0] CNT_LAST = STARVE_W'(STARVE_MAX - 1);
  localparam logic [STARVE_W-1:0] CNT_SAT  = '1;

  logic [STARVE_W-1:0] starve_cnt;

  assign grant       = active & (~mem_s_req | (starve_cnt == CNT_LAST));
  assign s_own       = grant;
  assign mem_s_stall = grant & mem_s_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (start || grant) begin
      starve_cnt <= '0;
    end else if (active && (starve_cnt != CNT_SAT)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/tlb_op_seq.sv
// Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR committed in WB.
// state   | meaning
// IDLE    | waiting for a committed TLB op
// SRCH    | TLBP waiting for the search port
// PCOMMIT | TLBP result handed to cp0 Index
// RD      | TLBR waiting on registered TLB read data
// RCOMMIT | TLBR data handed to cp0
// WR      | TLB write strobe issued
// RFQ     | refetch requested, waiting for pre-IF ack
module tlb_op_seq
  import tlb_op_seq_pkg::*;
#(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM),
  parameter int STARVE_MAX   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  input  logic [1:0]              op_code,
  input  logic                    flush,
  output logic                    op_ready,
  output logic                    busy,
  output logic                    op_done,
  input  logic                    mem_s_req,
  output logic                    mem_s_stall,
  output logic                    s_own,
  input  logic                    s_found,
  input  logic [TLBNUM_WIDTH-1:0] s_index,
  output logic                    cp0_tlbp,
  output logic [TLBNUM_WIDTH:0]   cp0_tlbp_result,
  output logic                    cp0_tlbr,
  output logic                    tlb_we,
  output logic                    tlb_wr_random,
  output logic                    refetch_req,
  input  logic                    refetch_ack
);

  tlb_state_t state;
  logic       accept;
  logic       grant;

  assign accept   = (state == IDLE) & op_valid & ~flush;
  assign op_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  // TLBP finishes in PCOMMIT; everything else finishes on the refetch handshake.
  assign op_done  = cp0_tlbp | (refetch_req & refetch_ack);

  tlb_search_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .start      (accept && (op_code == TLBOP_P)),
    .active     (state == SRCH),
    .mem_s_req  (mem_s_req),
    .grant      (grant),
    .s_own      (s_own),
    .mem_s_stall(mem_s_stall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cp0_tlbp        <= 1'b0;
      cp0_tlbr        <= 1'b0;
      tlb_we          <= 1'b0;
      tlb_wr_random   <= 1'b0;
      refetch_req     <= 1'b0;
      cp0_tlbp_result <= '0;
    end else begin
      cp0_tlbp      <= 1'b0;
      cp0_tlbr      <= 1'b0;
      tlb_we        <= 1'b0;
      tlb_wr_random <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_code)
              TLBOP_P: state <= SRCH;
              TLBOP_R: state <= RD;
              default: begin
                state         <= WR;
                tlb_we        <= 1'b1;
                tlb_wr_random <= (op_code == TLBOP_WR);
              end
            endcase
          end
        end
        SRCH: begin
          if (grant) begin
            cp0_tlbp_result <= {~s_found, s_index};
            cp0_tlbp        <= 1'b1;
            state           <= PCOMMIT;
          end
        end
        PCOMMIT: state <= IDLE;
        RD: begin
          cp0_tlbr <= 1'b1;
          state    <= RCOMMIT;
        end
        RCOMMIT, WR: begin
          refetch_req <= 1'b1;
          state       <= RFQ;
        end
        RFQ: begin
          if (refetch_ack) begin
            refetch_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
